// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcode codes, sequencer state encoding and helpers for alu_op_sequencer.
package alu_op_sequencer_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_XOR = 4;
  localparam int OP_NOR = 5;
  localparam int OP_SLT = 6;
  localparam int OP_SLL = 7;
  localparam int OP_SRL = 8;
  localparam int OP_SRA = 9;
  localparam int OP_MUL = 10;
  localparam int OP_DIV = 11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_cycle_timer.sv
// cycle_timer: loadable down-counter that parks at zero and flags it.
module cycle_timer #(
  parameter int TW = 3
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [TW-1:0] count;

  always_ff @(posedge clock or posedge clear) begin
    if (clear)                    count <= '0;
    else if (load)                count <= load_val;
    else if (dec && count != '0)  count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: registers one ALU request, waits a per-class settle time, returns LO/HI.
// Build option DIV_ZERO_CHECK_EN: DIV by zero bypasses the ALU result and returns err=1, LO=HI=0.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int OP_W       = 5,
  parameter int SETTLE_CYC = 1,
  parameter int MULDIV_CYC = 4
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_b,
  input  logic [OP_W-1:0]     req_opcode,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OP_W-1:0]     alu_opcode,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_lo,
  output logic [DATA_W-1:0]   rsp_hi,
  output logic                rsp_hi_we,
  output logic                rsp_err,
  output logic                busy
);

  localparam int TW = $clog2(max_int(SETTLE_CYC, MULDIV_CYC)) + 1;
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] MULDIV_LD = TW'(MULDIV_CYC - 1);

  state_t        state, state_nxt;
  logic          accept, capture;
  logic          muldiv_req, dz_req;
  logic          muldiv_q, dz_q;
  logic          tmr_zero;
  logic [TW-1:0] tmr_load_val;

  assign muldiv_req = (req_opcode == OP_W'(OP_MUL)) || (req_opcode == OP_W'(OP_DIV));

`ifdef DIV_ZERO_CHECK_EN
  assign dz_req = (req_opcode == OP_W'(OP_DIV)) && (req_b == '0);
`else
  assign dz_req = 1'b0;
`endif

  // A zero divisor needs no settle time: capture on the very next edge.
  assign tmr_load_val = dz_req ? '0 : (muldiv_req ? MULDIV_LD : SETTLE_LD);

  cycle_timer #(.TW(TW)) u_timer (
    .clock    (clock),
    .clear    (clear),
    .load     (accept),
    .load_val (tmr_load_val),
    .dec      (state == S_WAIT),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: if (req_valid) begin
        accept    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: if (tmr_zero) begin
        capture   = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);

  // alu_* and rsp_* only move on accept/capture, so they hold under backpressure.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      muldiv_q   <= 1'b0;
      dz_q       <= 1'b0;
      rsp_lo     <= '0;
      rsp_hi     <= '0;
      rsp_hi_we  <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        alu_a      <= req_a;
        alu_b      <= req_b;
        alu_opcode <= req_opcode;
        muldiv_q   <= muldiv_req;
        dz_q       <= dz_req;
      end
      if (capture) begin
        rsp_lo    <= dz_q ? '0 : alu_result[DATA_W-1:0];
        rsp_hi    <= dz_q ? '0 : alu_result[2*DATA_W-1:DATA_W];
        rsp_hi_we <= muldiv_q & ~dz_q;
        rsp_err   <= dz_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU plus transaction-level timing model, directed and random traffic.
module tb_alu_op_sequencer;

  localparam int DW = 32;
  localparam int OW = 5;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          req_valid = 1'b0;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] req_a = '0, req_b = '0;
  logic [OW-1:0] req_opcode = '0;
  logic          req_ready, rsp_valid, rsp_hi_we, rsp_err, busy;
  logic [DW-1:0] alu_a, alu_b, rsp_lo, rsp_hi;
  logic [OW-1:0] alu_opcode;
  logic [2*DW-1:0] alu_result;

  int errors = 0;
  int checks = 0;

  alu_op_sequencer dut (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_hi_we(rsp_hi_we), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Stand-in for the real combinational ALU: {HI, LO}.
  function automatic logic [63:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      5'd0:  return {32'h0, a + b};
      5'd1:  return {32'h0, a - b};
      5'd2:  return {32'h0, a & b};
      5'd3:  return {32'h0, a | b};
      5'd4:  return {32'h0, a ^ b};
      5'd5:  return {32'h0, ~(a | b)};
      5'd6:  return {63'h0, ($signed(a) < $signed(b))};
      5'd7:  return {32'h0, a << b[4:0]};
      5'd8:  return {32'h0, a >> b[4:0]};
      5'd9:  return {32'h0, 32'($signed(a) >>> b[4:0])};
      5'd10: return 64'(sa * sb);
      5'd11: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return {b, a};
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_a, alu_b, alu_opcode);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction model: one op in flight, accepted at edge t0, result valid from edge t0+n.
  bit          pend = 1'b0;
  int          t0 = 0, n = 1, cyc = 0;
  logic [31:0] e_lo, e_hi, e_a, e_b;
  logic [4:0]  e_op;
  bit          e_we, e_err;
  bit          chk_en = 1'b0;

  always @(posedge clock) begin
    bit hs, md, dz;
    logic [63:0] r;
    hs = pend && (cyc >= t0 + n) && rsp_ready;
    cyc++;
    if (clear) pend = 1'b0;
    else if (!pend && req_valid) begin
      md = (req_opcode == 5'd10) || (req_opcode == 5'd11);
`ifdef DIV_ZERO_CHECK_EN
      dz = (req_opcode == 5'd11) && (req_b == 32'h0);
`else
      dz = 1'b0;
`endif
      r     = alu_fn(req_a, req_b, req_opcode);
      pend  = 1'b1;
      t0    = cyc;
      n     = dz ? 1 : (md ? 4 : 1);
      e_lo  = dz ? 32'h0 : r[31:0];
      e_hi  = dz ? 32'h0 : r[63:32];
      e_we  = md && !dz;
      e_err = dz;
      e_a   = req_a;
      e_b   = req_b;
      e_op  = req_opcode;
    end else if (hs) pend = 1'b0;
  end

  always @(negedge clock) begin
    bit rv;
    if (chk_en && !clear) begin
      rv = pend && (cyc >= t0 + n);
      chk("req_ready", 64'(req_ready), 64'(!pend));
      chk("busy", 64'(busy), 64'(pend));
      chk("rsp_valid", 64'(rsp_valid), 64'(rv));
      if (rv) begin
        chk("rsp_lo", 64'(rsp_lo), 64'(e_lo));
        chk("rsp_hi", 64'(rsp_hi), 64'(e_hi));
        chk("rsp_hi_we", 64'(rsp_hi_we), 64'(e_we));
        chk("rsp_err", 64'(rsp_err), 64'(e_err));
      end
      if (pend) begin
        chk("alu_a", 64'(alu_a), 64'(e_a));
        chk("alu_b", 64'(alu_b), 64'(e_b));
        chk("alu_opcode", 64'(alu_opcode), 64'(e_op));
      end
    end
  end

  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] op, input bit rr);
    @(posedge clock);
    #1;
    req_valid = v; req_a = a; req_b = b; req_opcode = op; rsp_ready = rr;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_alu_a"}, 64'(alu_a), 64'd0);
    chk({nm, "_alu_b"}, 64'(alu_b), 64'd0);
    chk({nm, "_alu_op"}, 64'(alu_opcode), 64'd0);
    chk({nm, "_lo"}, 64'(rsp_lo), 64'd0);
    chk({nm, "_hi"}, 64'(rsp_hi), 64'd0);
    chk({nm, "_hi_we"}, 64'(rsp_hi_we), 64'd0);
    chk({nm, "_err"}, 64'(rsp_err), 64'd0);
  endtask

  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] op, input int hold, input int x_lat,
                        input logic [31:0] x_lo, input logic [31:0] x_hi, input bit x_we, input bit x_err);
    int lat;
    step(1'b1, a, b, op, 1'b0);
    step(1'b0, 32'h0, 32'h0, 5'h0, 1'b0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step(1'b0, 32'h0, 32'h0, 5'h0, 1'b0);
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(x_lat));
    chk({nm, "_lo"}, 64'(rsp_lo), 64'(x_lo));
    chk({nm, "_hi"}, 64'(rsp_hi), 64'(x_hi));
    chk({nm, "_hi_we"}, 64'(rsp_hi_we), 64'(x_we));
    chk({nm, "_err"}, 64'(rsp_err), 64'(x_err));
    for (int i = 0; i < hold; i++) begin
      step(1'b1, 32'h1, 32'h1, 5'h0, 1'b0);
      chk({nm, "_hold_valid"}, 64'(rsp_valid), 64'd1);
      chk({nm, "_hold_req_ready"}, 64'(req_ready), 64'd0);
      chk({nm, "_hold_lo"}, 64'(rsp_lo), 64'(x_lo));
    end
    step(1'b0, 32'h0, 32'h0, 5'h0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 5'h0, 1'b0);
    chk({nm, "_ready_after"}, 64'(req_ready), 64'd1);
    chk({nm, "_valid_after"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int seen;
    logic [31:0] rb;
    #1 clear = 1'b1;
    #2;
    chk_all_zero("reset");
    @(posedge clock);
    #1 clear = 1'b0;
    chk_en = 1'b1;

    run_op("add",  32'd2,   32'd3,  5'd0,  0, 1, 32'd5,        32'd0,        1'b0, 1'b0);
    run_op("mul",  32'd12,  32'd17, 5'd10, 0, 4, 32'd204,      32'd0,        1'b1, 1'b0);
    run_op("div",  -32'sd17, 32'd3, 5'd11, 0, 4, 32'hFFFF_FFFB, 32'hFFFF_FFFE, 1'b1, 1'b0);
    run_op("and_bp", 32'd12, 32'd17, 5'd2, 2, 1, 32'd0,        32'd0,        1'b0, 1'b0);
    run_op("op15", 32'hAAAA_0001, 32'h5555_0002, 5'd15, 0, 1, 32'hAAAA_0001, 32'h5555_0002, 1'b0, 1'b0);
`ifdef DIV_ZERO_CHECK_EN
    run_op("div0", 32'd8, 32'd0, 5'd11, 0, 1, 32'd0, 32'd0, 1'b0, 1'b1);
`else
    run_op("div0", 32'd8, 32'd0, 5'd11, 0, 4, 32'hFFFF_FFFF, 32'd8, 1'b1, 1'b0);
`endif

    // Abort a MUL two cycles after accept.
    step(1'b1, 32'd3, 32'd5, 5'd10, 1'b0);
    step(1'b0, 32'h0, 32'h0, 5'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 5'h0, 1'b0);
    clear = 1'b1;
    #1;
    chk_all_zero("clear");
    @(posedge clock);
    #1 clear = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'h0, 32'h0, 5'h0, 1'b1);
      if (rsp_valid) seen++;
    end
    chk("clear_no_rsp", 64'(seen), 64'd0);

    for (int i = 0; i < 600; i++) begin
      rb = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      step($urandom_range(0, 2) != 0, $urandom, rb, 5'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 32'h0, 5'h0, 1'b1);

    chk("drained", 64'(busy), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
